rgmii_tx_sink: RTL and testbench
================================

// Module: rgmii_tx_sink
// PURPOSE
// - PHY-end decoder for the RGMII transmit path: turns the MAC's TD/TX_CTL/TXC stream back into byte-wide GMII.
// - Inputs are per-cycle DDR sample pairs from an ssio_ddr_in/iddr stage clocked by the 125 MHz gtx clock.
// - Handles 1G DDR bytes and 10/100 SDR nibble pairing; recovers TX_ER from the TX_CTL XOR encoding.
// - Used in PHY models, loopback benches and RGMII-to-GMII bridge designs.
// PARAMETERS
// - (none)
// PORTS
// clk             in   1  125 MHz sample clock; same clock as the MAC gtx clock
// rst             in   1  reset; asynchronous, active-high
// speed           in   2  2'b10 1G, 2'b01 100M, 2'b00 10M (2'b11 treated as 1G)
// in_txc_1        in   1  TXC sampled rising half of cycle
// in_txc_2        in   1  TXC sampled falling half of cycle
// in_td_1         in   4  TD rising half
// in_td_2         in   4  TD falling half
// in_ctl_1        in   1  TX_CTL rising half
// in_ctl_2        in   1  TX_CTL falling half
// gmii_txd        out  8  decoded byte
// gmii_tx_en      out  1  decoded TX_EN, qualified by gmii_valid
// gmii_tx_er      out  1  decoded TX_ER, qualified by gmii_valid
// gmii_valid      out  1  one-cycle strobe: gmii_* hold a new byte
// nibble_err      out  1  one-cycle pulse: odd nibble count or frame aborted by a speed change
// speed_eff       out  2  speed currently used by the decoder
// BEHAVIOUR
// - Reset: all outputs 0; speed_eff = 2'b10; assembler in S_IDLE; pending nibble cleared; all counters 0.
// - Reset mid-frame discards the partial byte and emits no pulse.
// 1G path
// - Every cycle registers gmii_txd = {in_td_2, in_td_1}, tx_en = in_ctl_1, tx_er = in_ctl_1 ^ in_ctl_2.
// - gmii_valid = 1 every cycle; latency 1 cycle.
// 10/100 path
// - Rise event: txc_2 of the previous cycle == 0 and in_txc_1 == 1.
// - At a rise event: nib = in_td_1; en = previous-cycle in_ctl_2 (low phase); er = en ^ in_ctl_1 (high phase).
// - Assembler FSM, advanced only on rise events:
//   - S_IDLE: en == 0 -> emit {4'h0, nib} with tx_en = 0, tx_er = er (carrier/ext visibility).
//     en == 1 -> store low nibble and its er; go to S_HI.
//   - S_HI, en == 1: emit byte {nib, lo_nib}, tx_en = 1, tx_er = er | lo_er; go to S_LO.
//   - S_HI, en == 0: drop lo_nib; pulse nibble_err; treat the nibble as in S_IDLE; go to S_IDLE.
//   - S_LO, en == 1: store the low nibble; go to S_HI.
//   - S_LO, en == 0: handle as S_IDLE.
// - Emitted bytes present gmii_valid on the cycle after the rise event; gmii_valid is 0 on all other cycles.
// - gmii_txd, gmii_tx_en and gmii_tx_er hold their last values between strobes.
// - speed_eff change while in S_HI or S_LO: return to S_IDLE; pulse nibble_err only if in S_HI.
// - Rise-event detection state clears on any speed_eff change.
// CONFIGURATION
// - RGMII_TX_SINK_SPEED_DETECT_EN defined:
//   - 6-bit counter measures clk cycles between rise events; it saturates at 63.
//   - Period 1 = 1G (in_txc_1 = 1 and in_txc_2 = 0 each cycle); period 5 = 100M; period 50 = 10M.
//   - speed_eff updates only after two consecutive identical matching periods.
//   - Any other period, or no rise event for 63 cycles: speed_eff holds. The speed input is ignored.
// - Macro undefined:
//   - speed_eff <= speed, registered; no detect logic is built.
// TESTING
// - 1G: td_1=4'h5, td_2=4'hD, ctl_1=1, ctl_2=1 -> next cycle txd=8'hD5, en=1, er=0, valid=1.
// - 1G: ctl_1=1, ctl_2=0 -> er=1; ctl_1=0, ctl_2=1 -> en=0, er=1 (carrier extend).
// - 100M: MAC-style TXC (low 3 cycles, high 2); send nibbles 5,5,D,5 with en=1 -> bytes 8'h55 then 8'h5D.
//   - Each valid comes 1 cycle after the second rise event; valid appears once per 10 cycles.
// - 10M: frame of 3 nibbles -> 1 byte, then nibble_err pulse on the rise event where en=0.
// - 100M: assert er on the high phase of one nibble -> the byte containing it has tx_er=1.
// - Reset asserted mid-frame in S_HI -> all outputs 0 immediately; no nibble_err.
// - With the macro: TXC at period 50 for 2 periods -> speed_eff=2'b00.
//   - Then constant 1G pattern -> speed_eff=2'b10 after 2 periods.
//   - Pending nibble during the switch -> nibble_err.

Source files
------------

// File: rtl/rgmii_tx_sink.sv
// rgmii_tx_sink: PHY-side RGMII transmit decoder back to byte-wide GMII (1G DDR, 10/100 nibbles).
// Define RGMII_TX_SINK_SPEED_DETECT_EN to derive speed_eff from the TXC period instead of speed.
module rgmii_tx_sink (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] speed,
   input  logic       in_txc_1,
   input  logic       in_txc_2,
   input  logic [3:0] in_td_1,
   input  logic [3:0] in_td_2,
   input  logic       in_ctl_1,
   input  logic       in_ctl_2,
   output logic [7:0] gmii_txd,
   output logic       gmii_tx_en,
   output logic       gmii_tx_er,
   output logic       gmii_valid,
   output logic       nibble_err,
   output logic [1:0] speed_eff
);

   typedef enum logic [1:0] {StIdle, StHi, StLo} asm_state_e;

   asm_state_e state_q, state_d;
   logic [1:0] speed_eff_q, speed_eff_d;
   logic       prev_txc2_q, prev_txc2_d;
   logic       prev_ctl2_q, prev_ctl2_d;
   logic [3:0] lo_nib_q, lo_nib_d;
   logic       lo_er_q, lo_er_d;
   logic [7:0] txd_q, txd_d;
   logic       en_q, en_d;
   logic       er_q, er_d;
   logic       valid_q, valid_d;
   logic       nerr_q, nerr_d;
   logic       spd_chg, rise, nib_en, nib_er;

   assign rise    = !prev_txc2_q && in_txc_1;
   assign nib_en  = prev_ctl2_q;
   assign nib_er  = prev_ctl2_q ^ in_ctl_1;
   assign spd_chg = (speed_eff_d != speed_eff_q);

`ifdef RGMII_TX_SINK_SPEED_DETECT_EN
   logic [5:0] cnt_q, cnt_d;
   logic [1:0] cand_q, cand_d;
   logic       cand_vld_q, cand_vld_d;
   logic       period_ok;
   logic [1:0] period_spd;
   logic       unused_speed;

   assign unused_speed = ^speed;

   // cnt_q holds the number of cycles since the last rise event, so it is the period at a rise.
   always_comb begin
      period_ok   = 1'b1;
      period_spd  = 2'b10;
      cnt_d       = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
      cand_d      = cand_q;
      cand_vld_d  = cand_vld_q;
      speed_eff_d = speed_eff_q;
      case (cnt_q)
         6'd1:    period_spd = 2'b10;
         6'd5:    period_spd = 2'b01;
         6'd50:   period_spd = 2'b00;
         default: period_ok  = 1'b0;
      endcase
      if (rise) begin
         cnt_d      = 6'd1;
         cand_d     = period_spd;
         cand_vld_d = period_ok;
         if (period_ok && cand_vld_q && (cand_q == period_spd)) speed_eff_d = period_spd;
      end else if (cnt_q == 6'd63) begin
         cand_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= 6'd0;
         cand_q     <= 2'b10;
         cand_vld_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         cand_q     <= cand_d;
         cand_vld_q <= cand_vld_d;
      end
   end
`else
   assign speed_eff_d = speed;
`endif

   always_comb begin
      state_d  = state_q;
      lo_nib_d = lo_nib_q;
      lo_er_d  = lo_er_q;
      txd_d    = txd_q;
      en_d     = en_q;
      er_d     = er_q;
      valid_d  = 1'b0;
      nerr_d   = 1'b0;
      // Held high after a speed change so a rise needs an observed low phase first.
      prev_txc2_d = spd_chg ? 1'b1 : in_txc_2;
      prev_ctl2_d = in_ctl_2;

      if (speed_eff_q[1]) begin
         txd_d   = {in_td_2, in_td_1};
         en_d    = in_ctl_1;
         er_d    = in_ctl_1 ^ in_ctl_2;
         valid_d = 1'b1;
      end

      if (spd_chg) begin
         state_d = StIdle;
         nerr_d  = (state_q == StHi);
      end else if (!speed_eff_q[1] && rise) begin
         if (nib_en && (state_q == StHi)) begin
            txd_d   = {in_td_1, lo_nib_q};
            en_d    = 1'b1;
            er_d    = nib_er | lo_er_q;
            valid_d = 1'b1;
            state_d = StLo;
         end else if (nib_en) begin
            lo_nib_d = in_td_1;
            lo_er_d  = nib_er;
            state_d  = StHi;
         end else begin
            txd_d   = {4'h0, in_td_1};
            en_d    = 1'b0;
            er_d    = nib_er;
            valid_d = 1'b1;
            nerr_d  = (state_q == StHi);
            state_d = StIdle;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         speed_eff_q <= 2'b10;
         prev_txc2_q <= 1'b1;
         prev_ctl2_q <= 1'b0;
         lo_nib_q    <= 4'h0;
         lo_er_q     <= 1'b0;
         txd_q       <= 8'h00;
         en_q        <= 1'b0;
         er_q        <= 1'b0;
         valid_q     <= 1'b0;
         nerr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         speed_eff_q <= speed_eff_d;
         prev_txc2_q <= prev_txc2_d;
         prev_ctl2_q <= prev_ctl2_d;
         lo_nib_q    <= lo_nib_d;
         lo_er_q     <= lo_er_d;
         txd_q       <= txd_d;
         en_q        <= en_d;
         er_q        <= er_d;
         valid_q     <= valid_d;
         nerr_q      <= nerr_d;
      end
   end

   assign gmii_txd   = txd_q;
   assign gmii_tx_en = en_q;
   assign gmii_tx_er = er_q;
   assign gmii_valid = valid_q;
   assign nibble_err = nerr_q;
   assign speed_eff  = speed_eff_q;

endmodule

// File: tb/tb_rgmii_tx_sink.sv
// Bench for rgmii_tx_sink: 1G vector table and random DDR bytes, 10/100 nibble streams
// scored against a frame-level pairing model, plus reset and speed-change corner cases.
module tb_rgmii_tx_sink;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] speed;
   logic       in_txc_1, in_txc_2, in_ctl_1, in_ctl_2;
   logic [3:0] in_td_1, in_td_2;
   logic [7:0] gmii_txd;
   logic       gmii_tx_en, gmii_tx_er, gmii_valid, nibble_err;
   logic [1:0] speed_eff;

   rgmii_tx_sink dut (
      .clk        (clk),
      .rst        (rst),
      .speed      (speed),
      .in_txc_1   (in_txc_1),
      .in_txc_2   (in_txc_2),
      .in_td_1    (in_td_1),
      .in_td_2    (in_td_2),
      .in_ctl_1   (in_ctl_1),
      .in_ctl_2   (in_ctl_2),
      .gmii_txd   (gmii_txd),
      .gmii_tx_en (gmii_tx_en),
      .gmii_tx_er (gmii_tx_er),
      .gmii_valid (gmii_valid),
      .nibble_err (nibble_err),
      .speed_eff  (speed_eff)
   );

   always #4 clk = ~clk;

   typedef struct packed {
      logic       en;
      logic       er;
      logic [3:0] nib;
   } nib_t;

   typedef struct packed {
      logic [3:0] td1;
      logic [3:0] td2;
      logic       ctl1;
      logic       ctl2;
      logic [7:0] txd;
      logic       en;
      logic       er;
   } vec_t;

   int         n_pass = 0;
   int         n_chk  = 0;
   int         cyc    = 0;
   int         seg_base;
   int         obs_err;
   logic       mon_on = 1'b0;
   nib_t       stream_q[$];
   logic [9:0] obs_q[$];
   int         vcyc_q[$];
   vec_t       vecs[6];

   // Every strobe seen while mon_on is logged as {tx_en, tx_er, txd} with its cycle number.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (mon_on) begin
         if (gmii_valid) begin
            obs_q.push_back({gmii_tx_en, gmii_tx_er, gmii_txd});
            vcyc_q.push_back(cyc);
         end
         if (nibble_err) obs_err++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic nib_t mk(input logic en, input logic er, input logic [3:0] nib);
      nib_t r;
      r.en  = en;
      r.er  = er;
      r.nib = nib;
      return r;
   endfunction

   task automatic drive_idle();
      in_txc_1 = 1'b0; in_txc_2 = 1'b0;
      in_td_1  = 4'h0; in_td_2  = 4'h0;
      in_ctl_1 = 1'b0; in_ctl_2 = 1'b0;
   endtask

   // All sequencing tasks start and end at a falling clock edge.
   task automatic do_reset();
      rst = 1'b1;
      drive_idle();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic set_mode(input logic [1:0] s);
      speed = s;
      do_reset();
   endtask

   // One TXC period of SDR nibble: TXC low for lo cycles carrying en, then high carrying en^er.
   task automatic send_nib(input int period, input int lo, input nib_t s);
      for (int c = 0; c < period; c++) begin
         in_txc_1 = (c >= lo);
         in_txc_2 = (c >= lo);
         in_td_1  = s.nib;
         in_td_2  = s.nib;
         in_ctl_1 = (c < lo) ? s.en : (s.en ^ s.er);
         in_ctl_2 = in_ctl_1;
         @(negedge clk);
      end
   endtask

   task automatic run_segment(input string name, input int period, input int lo);
      logic [9:0] exp_q[$];
      int         exp_err;
      int         run;
      logic [3:0] lo_nib;
      logic       lo_er;
      nib_t       s;
      exp_err  = 0;
      run      = 0;
      lo_nib   = 4'h0;
      lo_er    = 1'b0;
      obs_q.delete();
      vcyc_q.delete();
      obs_err  = 0;
      seg_base = cyc;
      mon_on   = 1'b1;
      foreach (stream_q[i]) send_nib(period, lo, stream_q[i]);
      @(negedge clk);
      mon_on = 1'b0;
      // Frame-level model: en runs pair up low-then-high; an odd run ends in an error.
      foreach (stream_q[i]) begin
         s = stream_q[i];
         if (s.en) begin
            if (run % 2 == 1) exp_q.push_back({1'b1, s.er | lo_er, s.nib, lo_nib});
            else begin
               lo_nib = s.nib;
               lo_er  = s.er;
            end
            run++;
         end else begin
            if (run % 2 == 1) exp_err++;
            run = 0;
            exp_q.push_back({1'b0, s.er, 4'h0, s.nib});
         end
      end
      check({name, " byte count"}, obs_q.size(), exp_q.size());
      check({name, " nibble_err count"}, obs_err, exp_err);
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check($sformatf("%s byte %0d", name, i), obs_q[i], exp_q[i]);
      stream_q.delete();
   endtask

   initial begin
      vecs[0] = '{4'h5, 4'hD, 1'b1, 1'b1, 8'hD5, 1'b1, 1'b0};
      vecs[1] = '{4'h5, 4'hD, 1'b1, 1'b0, 8'hD5, 1'b1, 1'b1};
      vecs[2] = '{4'h0, 4'h0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
      vecs[3] = '{4'hF, 4'h0, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0};
      vecs[4] = '{4'h3, 4'hC, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0};
      vecs[5] = '{4'hA, 4'h7, 1'b0, 1'b0, 8'h7A, 1'b0, 1'b0};

      speed = 2'b10;
      rst   = 1'b1;
      drive_idle();
      #1;
      check("reset outputs", {gmii_txd, gmii_tx_en, gmii_tx_er, gmii_valid, nibble_err, speed_eff},
            14'h0002);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         in_txc_1 = 1'b1; in_txc_2 = 1'b0;
         in_td_1  = vecs[i].td1;  in_td_2  = vecs[i].td2;
         in_ctl_1 = vecs[i].ctl1; in_ctl_2 = vecs[i].ctl2;
         @(posedge clk); #1;
         check($sformatf("1g vec %0d", i), {gmii_valid, gmii_tx_en, gmii_tx_er, gmii_txd},
               {1'b1, vecs[i].en, vecs[i].er, vecs[i].txd});
         @(negedge clk);
      end

      for (int i = 0; i < 30; i++) begin
         logic [10:0] exp;
         speed    = (i >= 15) ? 2'b11 : 2'b10;
         in_txc_1 = 1'b1; in_txc_2 = 1'b0;
         in_td_1  = 4'($urandom); in_td_2  = 4'($urandom);
         in_ctl_1 = 1'($urandom); in_ctl_2 = 1'($urandom);
         exp = {1'b1, in_ctl_1, in_ctl_1 ^ in_ctl_2, in_td_2, in_td_1};
         @(posedge clk); #1;
         check($sformatf("1g rand %0d", i), {gmii_valid, gmii_tx_en, gmii_tx_er, gmii_txd}, exp);
         @(negedge clk);
      end

`ifndef RGMII_TX_SINK_SPEED_DETECT_EN
      // 100M: 5,5,D,5 -> 55, 5D; strobes one cycle after each second rise, 10 cycles apart.
      set_mode(2'b01);
      check("100m speed_eff", speed_eff, 2'b01);
      stream_q = '{mk(1, 0, 4'h5), mk(1, 0, 4'h5), mk(1, 0, 4'hD), mk(1, 0, 4'h5), mk(0, 0, 4'h0)};
      run_segment("100m", 5, 3);
      if (obs_q.size() >= 2) begin
         check("100m first byte", obs_q[0], 10'h255);
         check("100m second byte", obs_q[1], 10'h25D);
         check("100m first strobe cycle", vcyc_q[0] - seg_base, 9);
         check("100m strobe spacing", vcyc_q[1] - vcyc_q[0], 10);
      end

      set_mode(2'b01);
      stream_q = '{mk(1, 0, 4'hA), mk(1, 1, 4'hB), mk(1, 0, 4'h1), mk(1, 0, 4'h2), mk(0, 0, 4'h0)};
      run_segment("100m er", 5, 3);
      if (obs_q.size() >= 2) begin
         check("100m er byte", obs_q[0], 10'h3BA);
         check("100m clean byte", obs_q[1], 10'h221);
      end

      set_mode(2'b00);
      stream_q = '{mk(1, 0, 4'h1), mk(1, 0, 4'h2), mk(1, 0, 4'h3), mk(0, 0, 4'h0)};
      run_segment("10m odd", 50, 25);
      if (obs_q.size() >= 1) check("10m byte", obs_q[0], 10'h221);
      check("10m nibble_err", obs_err, 1);

      set_mode(2'b01);
      for (int f = 0; f < 5; f++) begin
         int len = $urandom_range(1, 7);
         for (int k = 0; k < len; k++)
            stream_q.push_back(mk(1'b1, ($urandom_range(0, 3) == 0), 4'($urandom)));
         for (int k = 0; k < $urandom_range(1, 2); k++)
            stream_q.push_back(mk(1'b0, 1'($urandom), 4'($urandom)));
      end
      run_segment("100m rand", 5, 3);

      set_mode(2'b01);
      send_nib(5, 3, mk(1, 0, 4'h9));
      speed = 2'b10;
      @(posedge clk); #1;
      check("speed chg in hi", {nibble_err, speed_eff}, 3'b110);
      @(negedge clk);
      @(posedge clk); #1;
      check("speed chg pulse width", nibble_err, 1'b0);
      @(negedge clk);

      set_mode(2'b01);
      send_nib(5, 3, mk(1, 0, 4'h9));
      send_nib(5, 3, mk(1, 0, 4'h6));
      speed = 2'b10;
      @(posedge clk); #1;
      check("speed chg in lo", {nibble_err, speed_eff}, 3'b010);
      @(negedge clk);

      set_mode(2'b01);
      send_nib(5, 3, mk(1, 0, 4'h5));
      send_nib(5, 3, mk(1, 0, 4'h5));
      send_nib(5, 3, mk(1, 0, 4'h7));
      check("byte before reset", gmii_txd, 8'h55);
      #2 rst = 1'b1;
      #1;
      check("mid-frame reset outputs",
            {gmii_txd, gmii_tx_en, gmii_tx_er, gmii_valid, nibble_err, speed_eff}, 14'h0002);
      @(negedge clk);
      rst = 1'b0;
      drive_idle();
      obs_err = 0;
      mon_on  = 1'b1;
      repeat (6) @(negedge clk);
      mon_on = 1'b0;
      check("no nibble_err after reset", obs_err, 0);
`else
      set_mode(2'b11);
      for (int k = 0; k < 3; k++) send_nib(50, 25, mk(0, 0, 4'h0));
      check("detect 10m", speed_eff, 2'b00);
      for (int k = 0; k < 20 && speed_eff != 2'b10; k++) begin
         in_txc_1 = 1'b1; in_txc_2 = 1'b0; in_ctl_1 = 1'b0; in_ctl_2 = 1'b0;
         @(negedge clk);
      end
      check("detect 1g", speed_eff, 2'b10);
      for (int k = 0; k < 3; k++) send_nib(5, 3, mk(0, 0, 4'h0));
      check("detect 100m", speed_eff, 2'b01);
      send_nib(5, 3, mk(1, 0, 4'h4));
      obs_err = 0;
      mon_on  = 1'b1;
      for (int k = 0; k < 20; k++) begin
         in_txc_1 = 1'b1; in_txc_2 = 1'b0; in_ctl_1 = 1'b0; in_ctl_2 = 1'b0;
         @(negedge clk);
      end
      mon_on = 1'b0;
      check("detect pending nibble err", (obs_err != 0), 1'b1);
      check("detect back to 1g", speed_eff, 2'b10);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
